// File: rtl/mem_stage.sv
// mem_stage -- pipeline MEM stage with a 4096 x 32-bit data memory and the
// MEM/WB pipeline register.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   MemWriteM             store enable
//   memOpM[2:0]           000 word, 001 half signed, 010 half unsigned,
//                         011 byte signed, 100 byte unsigned, others = word
//   ResM[31:0]            byte address for loads/stores, or ALU result
//   MemWDM[31:0]          store data (low bits used for sh/sb)
//   PC4M[31:0]            PC+4 of the instruction in MEM
//   A3M[4:0], RegWriteM, MemtoRegM[1:0]   write-back controls
//   RDW, ResW, PC4W, A3W, RegWriteW, MemtoRegW   registered W-stage outputs
//
// Optional feature: define MEM_STAGE_DISPLAY_EN to compile a simulation-only
// log line for every committed store. Without it the block is plain
// synthesizable logic.
//
// Storage is cleared by reset, so it is built from flip-flops rather than a
// RAM macro; reads are combinational from it.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [2:0]  memOpM,
  input  logic [31:0] ResM,
  input  logic [31:0] MemWDM,
  input  logic [31:0] PC4M,
  input  logic [4:0]  A3M,
  input  logic        RegWriteM,
  input  logic [1:0]  MemtoRegM,
  output logic [31:0] RDW,
  output logic [31:0] ResW,
  output logic [31:0] PC4W,
  output logic [4:0]  A3W,
  output logic        RegWriteW,
  output logic [1:0]  MemtoRegW
);

  localparam int DEPTH = 4096;

  logic [31:0] mem [0:DEPTH-1];

  logic        in_range;
  logic [11:0] word_idx;
  logic [31:0] rd_word;
  logic        is_half;
  logic        is_byte;
  logic [3:0]  byte_en;
  logic [31:0] wr_lanes;
  logic [31:0] merged_word;
  logic [15:0] rd_half;
  logic [7:0]  rd_byte;
  logic [31:0] load_ext;

  assign in_range = (ResM[31:14] == 18'd0);
  assign word_idx = ResM[13:2];
  assign rd_word  = mem[word_idx];

  assign is_half = (memOpM == 3'b001) || (memOpM == 3'b010);
  assign is_byte = (memOpM == 3'b011) || (memOpM == 3'b100);

  // Store data replicated into every lane; the byte enables pick which lanes
  // actually take it, the rest keep the old word (read-modify-write).
  assign wr_lanes = is_byte ? {4{MemWDM[7:0]}} :
                    is_half ? {2{MemWDM[15:0]}} : MemWDM;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      always_comb begin
        if (is_byte)
          byte_en[gi] = (ResM[1:0] == 2'(gi));
        else if (is_half)
          byte_en[gi] = (ResM[1] == (gi >= 2));
        else
          byte_en[gi] = 1'b1;
      end
      assign merged_word[gi*8 +: 8] = byte_en[gi] ? wr_lanes[gi*8 +: 8]
                                                  : rd_word[gi*8 +: 8];
    end
  endgenerate

  // Storage: cleared on reset, written only for in-range stores.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'd0;
      end
    end else if (MemWriteM && in_range) begin
      mem[word_idx] <= merged_word;
    end
  end

  // Load selection and extension.
  assign rd_half = ResM[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    case (ResM[1:0])
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
  end

  always_comb begin
    load_ext = rd_word;
    case (memOpM)
      3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
      3'b010:  load_ext = {16'd0, rd_half};
      3'b011:  load_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_ext = {24'd0, rd_byte};
      default: load_ext = rd_word;
    endcase
    if (!in_range) load_ext = 32'd0;
  end

  // MEM/WB pipeline register; RDW updates every cycle, meaningful for loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      RDW       <= 32'd0;
      ResW      <= 32'd0;
      PC4W      <= 32'd0;
      A3W       <= 5'd0;
      RegWriteW <= 1'b0;
      MemtoRegW <= 2'd0;
    end else begin
      RDW       <= load_ext;
      ResW      <= ResM;
      PC4W      <= PC4M;
      A3W       <= A3M;
      RegWriteW <= RegWriteM;
      MemtoRegW <= MemtoRegM;
    end
  end

`ifdef MEM_STAGE_DISPLAY_EN
  // Store log: "<time>@<pc hex8>: *<aligned addr hex8> <= <merged word hex8>"
  always @(posedge clk) begin
    if (!reset && MemWriteM && in_range) begin
      $display("%0t@%h: *%h <= %h", $time, PC4M - 32'd4,
               {ResM[31:2], 2'b00}, merged_word);
    end
  end
`else
`endif

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Clock is clk and reset is reset; reset is synchronous and active-high.
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- MemWriteM  in  1  store enable.
- memOpM  in  3  access type: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned, others treated as word.
- ResM  in  32  byte address (load/store), or ALU result.
- MemWDM  in  32  store data; low bits are used for sh/sb.
- PC4M  in  32  PC+4 of the instruction in MEM.
- A3M  in  5  destination register.
- RegWriteM  in  1  register write enable.
- MemtoRegM  in  2  write-back source select.
- RDW  out  32  registered, extended load data.
- ResW  out  32  registered ResM.
- PC4W  out  32  registered PC4M.
- A3W  out  5  registered A3M.
- RegWriteW  out  1  registered RegWriteM.
- MemtoRegW  out  2  registered MemtoRegM.

Function
REQ-003 Storage SHALL be 4096 x 32-bit words; the word index is ResM[13:2].
REQ-004 An address is in range when ResM[31:14]==0.
- Out-of-range stores SHALL be suppressed.
- Out-of-range loads SHALL return 0.
REQ-005 Reads SHALL be combinational from storage.
- The extended result SHALL be captured into RDW on the next posedge, giving a 1-cycle latency to W.
REQ-006 Stores SHALL commit on posedge clk when MemWriteM=1, reset=0 and the address is in range.
REQ-007 Word store (op 000 or undefined) SHALL write all 32 bits and ignore ResM[1:0].
REQ-008 Half store (op 001/010) SHALL write MemWDM[15:0] to:
- bits [31:16] when ResM[1]=1;
- bits [15:0] otherwise.
- ResM[0] is ignored; other bits are preserved.
REQ-009 Byte store (op 011/100) SHALL write MemWDM[7:0] to bits [8*ResM[1:0]+7 : 8*ResM[1:0]]; other bits are preserved.
REQ-010 Word load SHALL return the full word.
REQ-011 Half load SHALL select the half by ResM[1].
- Op 001 SHALL sign-extend; op 010 SHALL zero-extend.
REQ-012 Byte load SHALL select the byte by ResM[1:0].
- Op 011 SHALL sign-extend; op 100 SHALL zero-extend.
REQ-013 RDW SHALL be updated every cycle regardless of MemtoRegM; the value is meaningful only for loads.
REQ-014 ResW, PC4W, A3W, RegWriteW and MemtoRegW SHALL copy their M inputs on each posedge when reset=0 (no stall or flush inputs).
REQ-015 A load issued the cycle after a store to the same word SHALL observe the stored data, because the store commits at the preceding edge.
REQ-016 Storage contents SHALL persist across cycles with MemWriteM=0.

Reset
REQ-017 On a posedge with reset=1:
- all W outputs SHALL become 0;
- all 4096 storage words SHALL become 0.
REQ-018 A store presented in a reset cycle SHALL NOT commit.
REQ-019 Reset asserted mid-sequence SHALL discard in-flight W contents; the first post-reset cycle behaves as from power-on.

Configuration
REQ-020 Macro MEM_STAGE_DISPLAY_EN SHALL gate a simulation-only write log.
REQ-021 With MEM_STAGE_DISPLAY_EN defined, each committed store SHALL print one line "<time>@<PC4M-4 hex8>: *<word-aligned address hex8> <= <merged full word hex8>".
- Suppressed or reset-cycle stores SHALL print nothing.
REQ-022 With MEM_STAGE_DISPLAY_EN undefined, no display code is compiled and the block is fully synthesizable; behaviour is otherwise identical.

Verification
REQ-023 Reset clears the block:
- Stimulus: reset 1 cycle, then load op 000 at 0x00000010.
- Response: RDW=0; all W outputs were 0 during reset.
REQ-024 Word store then half/byte loads:
- Stimulus: sw 0x8badf00d at 0x4; then lh 0x6, lhu 0x6, lb 0x7, lbu 0x4.
- Response: RDW = 0xffff8bad, 0x00008bad, 0xffffff8b, 0x0000000d on successive cycles.
REQ-025 Byte store into a zeroed word:
- Stimulus: sb MemWDM=0x123456ab at 0x9, then lw 0x8.
- Response: RDW=0x0000ab00; with the macro, log shows "*00000008 <= 0000ab00".
REQ-026 Half store into an all-ones word:
- Stimulus: sw 0xffffffff at 0xc; sh 0x00001234 at 0xe; lw 0xc.
- Response: RDW=0x1234ffff.
REQ-027 Out-of-range store is suppressed:
- Stimulus: sw 0xdeadbeef at 0x00004000, then lw 0x0.
- Response: RDW=0; no log line.
REQ-028 Reset blocks a store:
- Stimulus: sw 0x11111111 at 0x20 with reset=1; then lw 0x20 after reset drops; also A3M=5, RegWriteM=1.
- Response: RDW=0; A3W=5 and RegWriteW=1 one cycle after reset drops.
